// File: rtl/fc_operand_loader.sv
// Assembles a bias + LAYER_SZ (weight, input) beat stream into packed neuron operands, ping-pong buffered.
// Latency: frame presented the cycle after its last beat; in_ready drops only while both banks are full.
module fc_operand_loader #(
    parameter int SIZE     = 16,
    parameter int LAYER_SZ = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SIZE-1:0]          in_a,
    input  logic [SIZE-1:0]          in_b,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SIZE-1:0]          out_bias,
    output logic [LAYER_SZ*SIZE-1:0] out_weights,
    output logic [LAYER_SZ*SIZE-1:0] out_inputs,
    output logic                     frame_err
);

    localparam int             CW      = $clog2(LAYER_SZ + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(LAYER_SZ);

    logic [SIZE-1:0]          bias_q [2];
    logic [LAYER_SZ*SIZE-1:0] wgt_q  [2];
    logic [LAYER_SZ*SIZE-1:0] inp_q  [2];

    logic [1:0]    full_q, full_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          frame_err_q, frame_err_d;

    logic accept, at_end, frame_done, consume;

    assign in_ready   = !full_q[wr_ptr_q];
    assign accept     = in_valid && in_ready;
    assign at_end     = (cnt_q == CNT_MAX);
    assign frame_done = accept && at_end && in_last;
    assign consume    = full_q[rd_ptr_q] && out_ready;

    // Fill and drain always target different banks, so both updates can land in one cycle.
    always_comb begin
        full_d      = full_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        frame_err_d = 1'b0;
        if (accept) begin
            if (frame_done) begin
                full_d[wr_ptr_q] = 1'b1;
                wr_ptr_d         = !wr_ptr_q;
                cnt_d            = '0;
            end else if (in_last || at_end) begin
                frame_err_d = 1'b1;
                cnt_d       = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (consume) begin
            full_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = !rd_ptr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q      <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            full_q      <= full_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Beat k lands in element k-1; element 0 sits in the most significant slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                bias_q[b] <= '0;
                wgt_q[b]  <= '0;
                inp_q[b]  <= '0;
            end
        end else if (accept) begin
            if (cnt_q == '0) begin
                bias_q[wr_ptr_q] <= in_a;
            end
            for (int i = 0; i < LAYER_SZ; i++) begin
                if (cnt_q == CW'(i + 1)) begin
                    wgt_q[wr_ptr_q][(LAYER_SZ-i)*SIZE-1 -: SIZE] <= in_a;
                    inp_q[wr_ptr_q][(LAYER_SZ-i)*SIZE-1 -: SIZE] <= in_b;
                end
            end
        end
    end

    assign out_valid   = full_q[rd_ptr_q];
    assign out_bias    = bias_q[rd_ptr_q];
    assign out_weights = wgt_q[rd_ptr_q];
    assign out_inputs  = inp_q[rd_ptr_q];
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_fc_operand_loader.sv
// Directed bench for fc_operand_loader: inputs driven after the falling edge, outputs sampled there too.
module tb_fc_operand_loader;

    localparam int S = 16;
    localparam int L = 10;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [S-1:0]   in_a = '0;
    logic [S-1:0]   in_b = '0;
    logic           in_last = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [S-1:0]   out_bias;
    logic [L*S-1:0] out_weights;
    logic [L*S-1:0] out_inputs;
    logic           frame_err;

    int n_tests = 0;
    int n_fail  = 0;
    int n_acc   = 0;

    fc_operand_loader #(.SIZE(S), .LAYER_SZ(L)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_bias(out_bias), .out_weights(out_weights), .out_inputs(out_inputs),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Expected packed vector: element i = base + i, element 0 in the top 16 bits.
    function automatic logic [L*S-1:0] exp_vec(input logic [S-1:0] base);
        logic [L*S-1:0] v;
        v = '0;
        for (int i = 0; i < L; i++) v = (v << S) | (L*S)'(base + S'(i));
        return v;
    endfunction

    // Offer one beat; returns at the falling edge after it was accepted.
    task automatic beat(input logic [S-1:0] a, input logic [S-1:0] b, input logic last);
        logic ok;
        bit   done;
        done = 0;
        in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
        for (int t = 0; t < 50 && !done; t++) begin
            ok = in_ready;
            @(posedge clk); @(negedge clk);
            if (ok) done = 1;
        end
        in_valid = 1'b0; in_last = 1'b0;
        if (done) n_acc++;
        else begin
            n_tests++; n_fail++;
            $display("FAIL beat_timeout: beat a=%h never accepted within 50 cycles", a);
        end
    endtask

    task automatic send_frame(input logic [S-1:0] bias, input logic [S-1:0] wb, input logic [S-1:0] ib);
        beat(bias, '0, 1'b0);
        for (int k = 1; k <= L; k++) beat(wb + S'(k-1), ib + S'(k-1), k == L);
    endtask

    task automatic consume_one;
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b need 0", out_valid); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b need 1", in_ready); end
        n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b need 0", frame_err); end
        n_tests++; if (out_bias !== '0) begin n_fail++; $display("FAIL reset_bias: got %h need 0", out_bias); end
        n_tests++; if (out_weights !== '0 || out_inputs !== '0) begin n_fail++; $display("FAIL reset_vectors: got w=%h i=%h need 0", out_weights, out_inputs); end
    endtask

    task automatic test_single_frame;
        logic [L*S-1:0] w;
        logic [L*S-1:0] x;
        beat(16'h0800, '0, 1'b0);
        for (int k = 1; k < L; k++) beat(16'h0100 + S'(k-1), 16'h0200 + S'(k-1), 1'b0);
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b need 0", out_valid); end
        beat(16'h0109, 16'h0209, 1'b1);
        w = out_weights; x = out_inputs;
        n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b need 1", out_valid); end
        n_tests++; if (out_bias !== 16'h0800) begin n_fail++; $display("FAIL single_bias: got %h need 0800", out_bias); end
        n_tests++; if (w[(L-3)*S-1 -: S] !== 16'h0103) begin n_fail++; $display("FAIL single_w3: got %h need 0103", w[(L-3)*S-1 -: S]); end
        n_tests++; if (x[(L-9)*S-1 -: S] !== 16'h0209) begin n_fail++; $display("FAIL single_i9: got %h need 0209", x[(L-9)*S-1 -: S]); end
        n_tests++; if (w[L*S-1 -: S] !== 16'h0100) begin n_fail++; $display("FAIL single_w0_top: got %h need 0100", w[L*S-1 -: S]); end
        n_tests++; if (w !== exp_vec(16'h0100) || x !== exp_vec(16'h0200)) begin n_fail++; $display("FAIL single_vectors: got w=%h i=%h", w, x); end
        consume_one();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %b need 0", out_valid); end
    endtask

    task automatic test_backpressure;
        int acc0;
        acc0 = n_acc;
        send_frame(16'h1001, 16'h1110, 16'h1210);
        send_frame(16'h1002, 16'h1120, 16'h1220);
        n_tests++; if (n_acc - acc0 !== 22) begin n_fail++; $display("FAIL bp_accepted: got %0d need 22", n_acc - acc0); end
        // Frame 3 bias is offered while both banks are full; it must not be taken.
        in_valid = 1'b1; in_a = 16'h1003; in_b = '0; in_last = 1'b0;
        repeat (3) begin
            n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_low: got %b need 0", in_ready); end
            @(posedge clk); @(negedge clk);
        end
        n_tests++; if (out_valid !== 1'b1 || out_bias !== 16'h1001) begin n_fail++; $display("FAIL bp_frame1_held: valid=%b bias=%h need 1/1001", out_valid, out_bias); end
        n_tests++; if (out_weights !== exp_vec(16'h1110)) begin n_fail++; $display("FAIL bp_frame1_w: got %h", out_weights); end
        consume_one();
        n_tests++; if (out_valid !== 1'b1 || out_bias !== 16'h1002) begin n_fail++; $display("FAIL bp_frame2: valid=%b bias=%h need 1/1002", out_valid, out_bias); end
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_back: got %b need 1", in_ready); end
        send_frame(16'h1003, 16'h1130, 16'h1230);
        n_tests++; if (out_weights !== exp_vec(16'h1120) || out_inputs !== exp_vec(16'h1220)) begin n_fail++; $display("FAIL bp_frame2_data: w=%h i=%h", out_weights, out_inputs); end
        consume_one();
        n_tests++; if (out_valid !== 1'b1 || out_bias !== 16'h1003 || out_weights !== exp_vec(16'h1130) || out_inputs !== exp_vec(16'h1230)) begin
            n_fail++; $display("FAIL bp_frame3: valid=%b bias=%h w=%h", out_valid, out_bias, out_weights); end
        consume_one();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b need 0", out_valid); end
    endtask

    task automatic test_early_last;
        beat(16'h2000, '0, 1'b0);
        for (int k = 1; k <= 5; k++) beat(16'h2100 + S'(k), 16'h2200 + S'(k), k == 5);
        n_tests++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL early_err_pulse: got %b need 1", frame_err); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL early_no_valid: got %b need 0", out_valid); end
        @(posedge clk); @(negedge clk);
        n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL early_err_width: got %b need 0", frame_err); end
        send_frame(16'h2800, 16'h2300, 16'h2400);
        n_tests++; if (out_valid !== 1'b1 || out_bias !== 16'h2800 || out_weights !== exp_vec(16'h2300) || out_inputs !== exp_vec(16'h2400)) begin
            n_fail++; $display("FAIL early_next_frame: valid=%b bias=%h w=%h", out_valid, out_bias, out_weights); end
        consume_one();
    endtask

    task automatic test_missing_last;
        beat(16'h3000, '0, 1'b0);
        for (int k = 1; k <= L; k++) beat(16'h3100 + S'(k), 16'h3200 + S'(k), 1'b0);
        n_tests++; if (frame_err !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL missing_err: err=%b valid=%b need 1/0", frame_err, out_valid); end
        send_frame(16'h3800, 16'h3300, 16'h3400);
        n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL missing_err_clear: got %b need 0", frame_err); end
        n_tests++; if (out_valid !== 1'b1 || out_bias !== 16'h3800 || out_weights !== exp_vec(16'h3300) || out_inputs !== exp_vec(16'h3400)) begin
            n_fail++; $display("FAIL missing_next_frame: valid=%b bias=%h w=%h", out_valid, out_bias, out_weights); end
        consume_one();
    endtask

    task automatic test_reset_mid;
        send_frame(16'h4800, 16'h4100, 16'h4200);
        beat(16'h4900, '0, 1'b0);
        for (int k = 1; k <= 5; k++) beat(16'h4500 + S'(k), 16'h4600 + S'(k), 1'b0);
        rst_n = 1'b0;
        #1;
        n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_flags: valid=%b ready=%b need 0/1", out_valid, in_ready); end
        n_tests++; if (out_bias !== '0 || out_weights !== '0 || out_inputs !== '0) begin n_fail++; $display("FAIL rst_mid_data: bias=%h w=%h", out_bias, out_weights); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(16'h4A00, 16'h4B00, 16'h4C00);
        n_tests++; if (out_valid !== 1'b1 || out_bias !== 16'h4A00 || out_weights !== exp_vec(16'h4B00) || out_inputs !== exp_vec(16'h4C00)) begin
            n_fail++; $display("FAIL rst_mid_next_frame: valid=%b bias=%h w=%h", out_valid, out_bias, out_weights); end
        consume_one();
    endtask

    task automatic test_back_to_back;
        send_frame(16'h5A00, 16'h5100, 16'h5200);
        beat(16'h5B00, '0, 1'b0);
        for (int k = 1; k < L; k++) beat(16'h5300 + S'(k-1), 16'h5400 + S'(k-1), 1'b0);
        n_tests++; if (out_bias !== 16'h5A00 || in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_frameA: bias=%h ready=%b need 5a00/1", out_bias, in_ready); end
        in_valid = 1'b1; in_a = 16'h5309; in_b = 16'h5409; in_last = 1'b1; out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        n_tests++; if (out_valid !== 1'b1 || out_bias !== 16'h5B00 || out_weights !== exp_vec(16'h5300) || out_inputs !== exp_vec(16'h5400)) begin
            n_fail++; $display("FAIL b2b_frameB: valid=%b bias=%h w=%h", out_valid, out_bias, out_weights); end
        consume_one();
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b need 0", out_valid); end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_single_frame();
        test_backpressure();
        test_early_last();
        test_missing_last();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
